// File: rtl/alu_pkg.sv
// Shared opcode, state and flag definitions for the sequential ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        CMD_ADD  = 4'h0,
        CMD_SHL  = 4'h1,
        CMD_SHR  = 4'h2,
        CMD_MOV  = 4'h3,
        CMD_OR   = 4'h4,
        CMD_XOR  = 4'h5,
        CMD_AND  = 4'h6,
        CMD_ADDI = 4'h7,
        CMD_BNE  = 4'h8,
        CMD_BEQ  = 4'h9,
        CMD_MOVI = 4'hA,
        CMD_MUL  = 4'hB,
        CMD_CLC  = 4'hC,
        CMD_CMP  = 4'hD,
        CMD_NOP  = 4'hF
    } alu_cmd_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2
    } alu_state_e;

    // Registered status flags presented alongside the result.
    typedef struct packed {
        logic sc;
        logic zero;
        logic pari;
        logic equal;
    } alu_flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Controller-to-ALU bundle: launch handshake, operands and registered results.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = $clog2(WIDTH) + 1
);
    logic             start_i;
    logic [3:0]       cmd_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [AMT_W-1:0] amt_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] rslt_o;
    logic [WIDTH-1:0] rslt_hi_o;
    logic             sc_o;
    logic             zero_o;
    logic             pari_o;
    logic             equal_o;

    modport master (
        output start_i, cmd_i, a_i, b_i, amt_i,
        input  busy_o, done_o, rslt_o, rslt_hi_o, sc_o, zero_o, pari_o, equal_o
    );

    modport slave (
        input  start_i, cmd_i, a_i, b_i, amt_i,
        output busy_o, done_o, rslt_o, rslt_hi_o, sc_o, zero_o, pari_o, equal_o
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// done_c/prod_c flag the final step combinationally so the owner can commit on that edge.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done_c,
    output logic [2*WIDTH-1:0] prod_c
);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [PW-1:0]    mcand_q;
    logic [PW-1:0]    acc_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    // Partial product after consuming the current multiplier LSB.
    always_comb begin
        prod_c = acc_q + (mplier_q[0] ? mcand_q : '0);
        done_c = busy_q && (cnt_q == CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= PW'(a);
            acc_q    <= '0;
            mplier_q <= b;
            cnt_q    <= CNT_W'(WIDTH);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= prod_c;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNT_W'(1);
            if (done_c) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with persistent carry, rotate-through-carry shifts and an
// iterative multiplier behind a start/busy/done handshake.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);
    localparam int unsigned PW = 2 * WIDTH;

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] rslt_q, rslt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    alu_flags_t       flags_q, flags_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] sh_r_q, sh_r_d;
    logic             sh_c_q, sh_c_d;
    logic             sh_left_q, sh_left_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] rot_r_c;
    logic             rot_c_c;
    logic             wr_rslt_c;
    logic             mul_start_c;
    logic             mul_busy;
    logic             mul_done_c;
    logic [PW-1:0]    mul_prod_c;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start_c),
        .a      (bus.a_i),
        .b      (bus.b_i),
        .busy   (mul_busy),
        .done_c (mul_done_c),
        .prod_c (mul_prod_c)
    );

    // One step of the (WIDTH+1)-bit rotate through the working carry.
    always_comb begin
        if (sh_left_q) begin
            {rot_c_c, rot_r_c} = {sh_r_q, sh_c_q};
        end else begin
            {rot_r_c, rot_c_c} = {sh_c_q, sh_r_q};
        end
    end

    always_comb begin
        state_d     = state_q;
        rslt_d      = rslt_q;
        hi_d        = hi_q;
        flags_d     = flags_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        sh_r_d      = sh_r_q;
        sh_c_d      = sh_c_q;
        sh_left_d   = sh_left_q;
        cnt_d       = cnt_q;
        wr_rslt_c   = 1'b0;
        mul_start_c = 1'b0;
        sum_c       = (WIDTH+1)'(bus.a_i) + (WIDTH+1)'(bus.b_i) + (WIDTH+1)'(flags_q.sc);

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    done_d = 1'b1;
                    case (bus.cmd_i)
                        CMD_ADD, CMD_ADDI: begin
                            {flags_d.sc, rslt_d} = sum_c;
                            hi_d      = '0;
                            wr_rslt_c = 1'b1;
                        end
                        CMD_OR, CMD_XOR, CMD_AND: begin
                            if (bus.cmd_i == CMD_OR) begin
                                rslt_d = bus.a_i | bus.b_i;
                            end else if (bus.cmd_i == CMD_XOR) begin
                                rslt_d = bus.a_i ^ bus.b_i;
                            end else begin
                                rslt_d = bus.a_i & bus.b_i;
                            end
                            flags_d.sc = 1'b0;
                            hi_d       = '0;
                            wr_rslt_c  = 1'b1;
                        end
                        CMD_BNE, CMD_BEQ, CMD_CMP: begin
                            flags_d.equal = (bus.a_i == bus.b_i);
                        end
                        CMD_CLC: begin
                            flags_d.sc = 1'b0;
                            hi_d       = '0;
                        end
                        CMD_SHL, CMD_SHR: begin
                            if (bus.amt_i == '0) begin
                                rslt_d    = bus.a_i;
                                hi_d      = '0;
                                wr_rslt_c = 1'b1;
                            end else begin
                                done_d    = 1'b0;
                                busy_d    = 1'b1;
                                state_d   = SHIFT;
                                sh_r_d    = bus.a_i;
                                sh_c_d    = flags_q.sc;
                                sh_left_d = (bus.cmd_i == CMD_SHL);
                                cnt_d     = bus.amt_i;
                            end
                        end
                        CMD_MUL: begin
                            done_d      = 1'b0;
                            busy_d      = 1'b1;
                            state_d     = MUL;
                            mul_start_c = 1'b1;
                        end
                        default: begin
                            // MOV, MOVI, NOP and unused encodings pass A through.
                            rslt_d     = bus.a_i;
                            flags_d.sc = 1'b0;
                            hi_d       = '0;
                            wr_rslt_c  = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT: begin
                sh_r_d = rot_r_c;
                sh_c_d = rot_c_c;
                if (cnt_q == AMT_W'(1)) begin
                    rslt_d     = rot_r_c;
                    flags_d.sc = rot_c_c;
                    hi_d       = '0;
                    wr_rslt_c  = 1'b1;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - AMT_W'(1);
                end
            end
            MUL: begin
                if (mul_done_c) begin
                    rslt_d     = mul_prod_c[WIDTH-1:0];
                    hi_d       = mul_prod_c[PW-1:WIDTH];
                    flags_d.sc = |mul_prod_c[PW-1:WIDTH];
                    wr_rslt_c  = 1'b1;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else if (!mul_busy) begin
                    // Engine idle without finishing: recover to IDLE rather than hang.
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (wr_rslt_c) begin
            flags_d.zero = (rslt_d == '0);
            flags_d.pari = ^rslt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rslt_q    <= '0;
            hi_q      <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            sh_r_q    <= '0;
            sh_c_q    <= 1'b0;
            sh_left_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rslt_q    <= rslt_d;
            hi_q      <= hi_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            sh_r_q    <= sh_r_d;
            sh_c_q    <= sh_c_d;
            sh_left_q <= sh_left_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.rslt_o    = rslt_q;
    assign bus.rslt_hi_o = hi_q;
    assign bus.sc_o      = flags_q.sc;
    assign bus.zero_o    = flags_q.zero;
    assign bus.pari_o    = flags_q.pari;
    assign bus.equal_o   = flags_q.equal;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU, sitting between the register file and writeback in the processor core.
- Adds a persistent carry flag, multi-bit shifts that rotate through carry and take multiple cycles, and an iterative shift-add multiplier.
- A start/busy/done handshake lets the controller stall while a multi-cycle operation completes.
- All results and flags are registered and held until the next completed operation.

Parameters:
WIDTH, 8, datapath width in bits (≥4)
AMT_W, $clog2(WIDTH)+1, shift-amount width (allows amt = WIDTH)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  launch operation; sampled only in IDLE
cmd_i  in  4  opcode (see Behaviour)
a_i  in  WIDTH  operand A
b_i  in  WIDTH  operand B / immediate
amt_i  in  AMT_W  shift count for SHL/SHR
busy_o  out  1  high while a multi-cycle op is in flight
done_o  out  1  one-cycle pulse when the result/flags update
rslt_o  out  WIDTH  result (low half for MUL)
rslt_hi_o  out  WIDTH  MUL high half; 0 after every other op
sc_o  out  1  registered carry flag
zero_o  out  1  rslt_o == 0
pari_o  out  1  ^rslt_o
equal_o  out  1  registered equality flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0, including busy_o, done_o and the carry flag. Asserting reset mid-operation aborts the op; no done_o is produced.
- Opcodes: 0000 ADD; 0001 SHL; 0010 SHR; 0011 MOV; 0100 OR; 0101 XOR; 0110 AND; 0111 ADDI; 1000 BNE; 1001 BEQ; 1010 MOVI; 1011 MUL; 1100 CLC; 1101 CMP; 1111 NOP. Any unlisted opcode behaves as NOP.
- Single-cycle ops: start_i in IDLE → results register at that clock edge; done_o=1 for the following cycle; busy_o stays 0.
- ADD/ADDI: {c,r} = A + B + c (WIDTH+1-bit sum); c is the stored carry.
- MOV/MOVI/NOP: r = A. Logical ops (OR/XOR/AND): r = bitwise result.
  - MOV/MOVI/NOP, OR/XOR/AND and CLC all clear c.
- CMP/BEQ/BNE: equal_o = (A==B); rslt_o, rslt_hi_o, zero_o, pari_o and c are unchanged.
- CLC: rslt_o is unchanged.
- equal_o changes only on CMP/BEQ/BNE.
- zero_o/pari_o are recomputed from the new rslt_o on every op that writes rslt_o.
- SHL/SHR: go to state SHIFT with an internal r=A and cnt=amt_i.
  - Each cycle, SHL does {c,r} ← {r,c} and SHR does {r,c} ← {c,r}, i.e. a (WIDTH+1)-bit rotate through carry; cnt decrements.
  - When cnt reaches 0, commit to outputs and pulse done_o; latency = amt+1 cycles from start to done_o.
  - amt_i=0: behaves as a single-cycle op with r=A and c unchanged.
  - amt_i > WIDTH+1 is legal and rotates the full count.
- MUL: state MUL; unsigned shift-add, one multiplier bit per cycle for WIDTH cycles, then commit.
  - {rslt_hi_o, rslt_o} = A*B; c = |hi.
  - done_o arrives WIDTH+1 cycles after start.
- busy_o=1 in SHIFT/MUL and deasserts in the cycle done_o is high.
- start_i while busy_o=1 is ignored; no queueing.
- Operands are captured at start; later changes on a_i/b_i/amt_i do not affect the in-flight op.
- Outputs are stable between done_o pulses. During a multi-cycle op they hold the previous result.
- FSM: IDLE → (SHL/SHR, amt≠0) SHIFT; IDLE → (MUL) MUL; SHIFT/MUL → IDLE on completion. All other starts stay in IDLE.

Decomposition:
- Shared package alu_pkg: opcode localparams/enum alu_cmd_e (4-bit), state enum alu_state_e {IDLE, SHIFT, MUL}.
- One sub-module alu_mul_iter (start, A, B → busy/done, 2*WIDTH product), instantiated by alu_seq.
- Shifts and single-cycle ops live inline in alu_seq.

Test Plan:
- Reset, then ADD A=0xFF B=0x01 → rslt=0x00, sc=1, zero=1, pari=0, done_o pulses 1 cycle after start. Then ADD 0x00+0x00 → rslt=0x01, sc=0, pari=1.
- SHL A=0x81 amt=1 with c=0 → rslt=0x02, sc=1, latency 2. SHL A=0x81 amt=2 with c=0 → rslt=0x05, sc=0, busy high 2 cycles.
- SHR A=0x01 amt=1 with c=1 → rslt=0x80, sc=1. SHL amt=0 A=0x3C → rslt=0x3C, sc unchanged, single-cycle.
- MUL A=0xFF B=0xFF → rslt_hi=0xFE, rslt=0x01, sc=1, done_o at start+9. MUL 0x0F×0x11 → hi=0x00, lo=0xFF, sc=0. Second start while busy is ignored.
- CMP A=0x5A B=0x5A → equal=1, rslt/sc unchanged. CMP 0x5A/0x5B → equal=0. CLC → sc=0.
- Pull rst_n low during cycle 3 of a MUL → all outputs 0 asynchronously, no done_o. After release, ADD starts cleanly from IDLE.
